// File: rtl/demux_dispatch_ctrl_pkg.sv
// Shared types and helpers for the 1x4 demux dispatch controller.
package demux_dispatch_ctrl_pkg;

   localparam int NUM_OUT = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DRIVE  = 2'd2
   } state_t;

   function automatic logic [NUM_OUT-1:0] onehot4(input logic [1:0] sel);
      return 4'b0001 << sel;
   endfunction

endpackage

// File: rtl/demux_dispatch_ctrl_if.sv
// Upstream word stream, demux drive lines and activity counters of the dispatcher.
interface demux_dispatch_ctrl_if #(
   parameter int DW = 4,
   parameter int CW = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [1:0]    in_dest;
   logic [DW-1:0] demux_a;
   logic [1:0]    demux_sel;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready;
   logic          busy;
   logic [CW-1:0] sel_switch_cnt;
   logic [CW-1:0] word_cnt;

   modport master (
      output in_valid, in_data, in_dest, out_ready,
      input  in_ready, demux_a, demux_sel, out_valid, busy, sel_switch_cnt, word_cnt
   );

   modport slave (
      input  in_valid, in_data, in_dest, out_ready,
      output in_ready, demux_a, demux_sel, out_valid, busy, sel_switch_cnt, word_cnt
   );
endinterface

// File: rtl/demux_dispatch_ctrl_sync_fifo.sv
// Small synchronous FIFO exposing head and next entries for look-ahead dispatch.
module sync_fifo #(
   parameter int W     = 6,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CNTW = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_push,
   input  logic [W-1:0]    i_data,
   input  logic            i_pop,
   output logic [W-1:0]    o_head,
   output logic [W-1:0]    o_next,
   output logic [CNTW-1:0] o_count,
   output logic            o_full,
   output logic            o_empty
);
   logic [W-1:0]    r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [CNTW-1:0] r_count;
   logic [AW-1:0]   w_rd_nxt;
   logic            w_push, w_pop;

   assign o_full   = (r_count == CNTW'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign w_push   = i_push && !o_full;
   assign w_pop    = i_pop && !o_empty;
   assign w_rd_nxt = r_rd_ptr + 1'b1;
   assign o_head   = r_mem[r_rd_ptr];
   assign o_next   = r_mem[w_rd_nxt];
   assign o_count  = r_count;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= w_rd_nxt;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end
endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Dispatch FSM: drains the word FIFO into the 1x4 demux with a settle bubble on select changes.
import demux_dispatch_ctrl_pkg::*;

module demux_dispatch_ctrl #(
   parameter int DW    = 4,
   parameter int DEPTH = 4,
   parameter int CW    = 16
) (
   input logic                  clk,
   input logic                  rst,
   demux_dispatch_ctrl_if.slave bus
);
   localparam int FW   = DW + 2;
   localparam int CNTW = $clog2(DEPTH) + 1;

   logic [FW-1:0]   w_head, w_next;
   logic [CNTW-1:0] w_count;
   logic            w_full, w_empty, w_push, w_pop, w_has_next;
   logic [1:0]      w_head_dest, w_next_dest;
   logic [DW-1:0]   w_head_data, w_next_data;

   state_t          r_state;
   logic            r_seen;
   logic [1:0]      r_sel;
   logic [DW-1:0]   r_a;
   logic [3:0]      r_ov;
   logic [CW-1:0]   r_sw_cnt, r_word_cnt;

   assign w_push      = bus.in_valid && !w_full;
   assign w_pop       = (r_state == DRIVE) && bus.out_ready[r_sel];
   assign w_has_next  = (w_count > CNTW'(1));
   assign w_head_dest = w_head[FW-1:DW];
   assign w_head_data = w_head[DW-1:0];
   assign w_next_dest = w_next[FW-1:DW];
   assign w_next_data = w_next[DW-1:0];

   sync_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  ({bus.in_dest, bus.in_data}),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_next  (w_next),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_seen     <= 1'b0;
         r_sel      <= '0;
         r_a        <= '0;
         r_ov       <= '0;
         r_sw_cnt   <= '0;
         r_word_cnt <= '0;
      end else begin
         // IDLE acts one cycle after it first sees data, fixing push-to-valid latency.
         r_seen <= (r_state == IDLE) && !w_empty;
         case (r_state)
            IDLE: begin
               if (r_seen && !w_empty) begin
                  r_a <= w_head_data;
                  if (w_head_dest == r_sel) begin
                     r_state <= DRIVE;
                     r_ov    <= onehot4(r_sel);
                  end else begin
                     r_sel   <= w_head_dest;
                     r_state <= SETTLE;
                     if (r_sw_cnt != {CW{1'b1}}) r_sw_cnt <= r_sw_cnt + 1'b1;
                  end
               end
            end
            SETTLE: begin
               r_state <= DRIVE;
               r_ov    <= onehot4(r_sel);
            end
            DRIVE: begin
               if (w_pop) begin
                  if (r_word_cnt != {CW{1'b1}}) r_word_cnt <= r_word_cnt + 1'b1;
                  if (w_has_next) begin
                     r_a <= w_next_data;
                     if (w_next_dest != r_sel) begin
                        r_sel   <= w_next_dest;
                        r_ov    <= '0;
                        r_state <= SETTLE;
                        if (r_sw_cnt != {CW{1'b1}}) r_sw_cnt <= r_sw_cnt + 1'b1;
                     end
                  end else begin
                     r_ov    <= '0;
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_ov    <= '0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready       = !w_full;
   assign bus.demux_a        = r_a;
   assign bus.demux_sel      = r_sel;
   assign bus.out_valid      = r_ov;
   assign bus.busy           = !w_empty || (r_state != IDLE);
   assign bus.sel_switch_cnt = r_sw_cnt;
   assign bus.word_cnt       = r_word_cnt;
endmodule
